// File: rtl/vector_sweep_pkg.sv
// Shared types and constants for the vector sweep driver and its settle timer.
package vector_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } sweep_state_t;

    // Bit i is the expected response for vector i; encodes resp = c | ~(a ^ b).
    localparam logic [7:0] EXP_TABLE_DEFAULT = 8'hEB;

    localparam int SETTLE_W = 4;

endpackage

// File: rtl/vector_sweep_driver_if.sv
// Stimulus/response bundle between the sweep driver (master) and the block under check.
interface vector_sweep_driver_if #(
    parameter int N_IN = 3
);

    logic              start;
    logic [N_IN-1:0]   vec;
    logic              vec_valid;
    logic              resp;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_IN:0]     mismatch_cnt;
    logic [N_IN-1:0]   first_fail;

    modport master (
        input  start,
        input  resp,
        output vec,
        output vec_valid,
        output busy,
        output done,
        output pass,
        output mismatch_cnt,
        output first_fail
    );

    modport slave (
        output start,
        output resp,
        input  vec,
        input  vec_valid,
        input  busy,
        input  done,
        input  pass,
        input  mismatch_cnt,
        input  first_fail
    );

endinterface

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter with a zero flag; sets how long each vector is held before sampling.
module sweep_settle_timer
    import vector_sweep_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                dec,
    input  logic [SETTLE_W-1:0] load_val,
    output logic                zero
);

    logic [SETTLE_W-1:0] count_q;

    // Load wins over decrement; the count saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/vector_sweep_driver.sv
// Exhaustive sweep of all N_IN-bit vectors against an expected truth table.
// Optional macro VECTOR_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module vector_sweep_driver
    import vector_sweep_pkg::*;
#(
    parameter int                    N_IN      = 3,
    parameter int                    SETTLE    = 2,
    parameter logic [(2**N_IN)-1:0]  EXP_TABLE = EXP_TABLE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vector_sweep_driver_if.master bus
);

    localparam logic [N_IN-1:0]     VEC_LAST    = '1;
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);

    sweep_state_t     state_q, state_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic             vec_valid_q, vec_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [N_IN:0]    cnt_q, cnt_d;
    logic [N_IN-1:0]  first_q, first_d;

    logic             timer_load;
    logic             timer_dec;
    logic             timer_zero;
    logic             resp_bad;
    logic             stop_now;

    sweep_settle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .dec      (timer_dec),
        .load_val (SETTLE_LOAD),
        .zero     (timer_zero)
    );

    assign resp_bad = (bus.resp != EXP_TABLE[vec_q]);

    // Next-state and result-register updates; resp only matters in SAMPLE.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        vec_valid_d = vec_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        timer_load  = 1'b0;
        timer_dec   = 1'b0;
`ifdef VECTOR_SWEEP_STOP_ON_FAIL_EN
        stop_now    = resp_bad;
`else
        stop_now    = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = DRIVE;
                    vec_d       = '0;
                    cnt_d       = '0;
                    first_d     = '0;
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
                    vec_valid_d = 1'b1;
                    timer_load  = 1'b1;
                end
            end
            DRIVE: begin
                if (timer_zero) begin
                    state_d = SAMPLE;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            SAMPLE: begin
                if (resp_bad) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '0) begin
                        first_d = vec_q;
                    end
                end
                // pass is judged on the count that already includes this sample.
                if ((vec_q == VEC_LAST) || stop_now) begin
                    state_d     = FINISH;
                    busy_d      = 1'b0;
                    vec_valid_d = 1'b0;
                    done_d      = 1'b1;
                    pass_d      = (cnt_d == '0);
                end else begin
                    state_d    = DRIVE;
                    vec_d      = vec_q + 1'b1;
                    timer_load = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            vec_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            cnt_q       <= '0;
            first_q     <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            vec_valid_q <= vec_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
        end
    end

    assign bus.vec          = vec_q;
    assign bus.vec_valid    = vec_valid_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.pass         = pass_q;
    assign bus.mismatch_cnt = cnt_q;
    assign bus.first_fail   = first_q;

endmodule
